// File: rtl/display_mode_ctrl.sv
// Display source selection and button-driven set-time FSM for the 8-digit clock display.
// Blinks the field under edit and issues a one-cycle load request with the edited time.
module display_mode_ctrl #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic [31:0] time_in,
    input  logic [31:0] sw_in,
    output logic [31:0] display,
    output logic [7:0]  blank,
    output logic [2:0]  mode,
    output logic        set_valid,
    output logic [31:0] set_value
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        SHOW_TIME = 3'd0,
        SHOW_SW   = 3'd1,
        SET_HOUR  = 3'd2,
        SET_MIN   = 3'd3,
        SET_SEC   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      edit_q, edit_d;
    logic [31:0]      display_q, display_d;
    logic [7:0]       blank_q, blank_d;
    logic             set_valid_q, set_valid_d;
    logic [31:0]      set_value_q, set_value_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             blink_clr_s;

    // Saturating-range BCD increment: anything at or above max (including bad digits) wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] field, input logic [7:0] max_v);
        logic [7:0] r;
        if (field >= max_v) begin
            r = 8'h00;
        end else if (field[3:0] >= 4'd9) begin
            r = {field[7:4] + 4'd1, 4'd0};
        end else begin
            r = {field[7:4], field[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Next-state, edit register and commit logic; btn_mode outranks btn_next outranks btn_inc.
    always_comb begin
        state_d     = state_q;
        edit_d      = edit_q;
        set_valid_d = 1'b0;
        set_value_d = set_value_q;
        case (state_q)
            SHOW_TIME: begin
                if (btn_mode) begin
                    state_d = SHOW_SW;
                end else if (btn_next) begin
                    state_d = SET_HOUR;
                    edit_d  = {time_in[31:8], 8'h00};
                end else begin
                    state_d = SHOW_TIME;
                end
            end
            SHOW_SW: begin
                if (btn_mode) begin
                    state_d = SHOW_TIME;
                end else begin
                    state_d = SHOW_SW;
                end
            end
            SET_HOUR: begin
                if (btn_mode) begin
                    state_d = SHOW_TIME;
                end else if (btn_next) begin
                    state_d = SET_MIN;
                end else if (btn_inc) begin
                    edit_d[31:24] = bcd_inc(edit_q[31:24], 8'h23);
                end else begin
                    state_d = SET_HOUR;
                end
            end
            SET_MIN: begin
                if (btn_mode) begin
                    state_d = SHOW_TIME;
                end else if (btn_next) begin
                    state_d = SET_SEC;
                end else if (btn_inc) begin
                    edit_d[23:16] = bcd_inc(edit_q[23:16], 8'h59);
                end else begin
                    state_d = SET_MIN;
                end
            end
            SET_SEC: begin
                if (btn_mode) begin
                    state_d = SHOW_TIME;
                end else if (btn_next) begin
                    state_d     = SHOW_TIME;
                    set_valid_d = 1'b1;
                    set_value_d = edit_q;
                end else if (btn_inc) begin
                    edit_d[15:8] = bcd_inc(edit_q[15:8], 8'h59);
                end else begin
                    state_d = SET_SEC;
                end
            end
            default: begin
                state_d = SHOW_TIME;
            end
        endcase
    end

    // Blink timer restarts on any edit or state change so the touched field is visible at once.
    always_comb begin
        blink_clr_s = btn_inc || (state_d != state_q);
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        if (blink_clr_s) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = phase_q;
        end
    end

    // Output words are computed from next-state values so they line up with mode.
    always_comb begin
        display_d = 32'h0000_0000;
        blank_d   = 8'h00;
        case (state_d)
            SHOW_TIME: begin
                display_d = time_in;
                blank_d   = 8'h00;
            end
            SHOW_SW: begin
                display_d = sw_in;
                blank_d   = 8'h00;
            end
            SET_HOUR: begin
                display_d = edit_d;
                blank_d   = phase_d ? 8'hC0 : 8'h00;
            end
            SET_MIN: begin
                display_d = edit_d;
                blank_d   = phase_d ? 8'h30 : 8'h00;
            end
            SET_SEC: begin
                display_d = edit_d;
                blank_d   = phase_d ? 8'h0C : 8'h00;
            end
            default: begin
                display_d = time_in;
                blank_d   = 8'h00;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SHOW_TIME;
            edit_q      <= 32'h0000_0000;
            display_q   <= 32'h0000_0000;
            blank_q     <= 8'h00;
            set_valid_q <= 1'b0;
            set_value_q <= 32'h0000_0000;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            edit_q      <= edit_d;
            display_q   <= display_d;
            blank_q     <= blank_d;
            set_valid_q <= set_valid_d;
            set_value_q <= set_value_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign display   = display_q;
    assign blank     = blank_q;
    assign mode      = state_q;
    assign set_valid = set_valid_q;
    assign set_value = set_value_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl with hand-computed expectations (BLINK_DIV = 4).
module tb_display_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_mode, btn_next, btn_inc;
    logic [31:0] time_in, sw_in;
    logic [31:0] display;
    logic [7:0]  blank;
    logic [2:0]  mode;
    logic        set_valid;
    logic [31:0] set_value;

    int checks = 0;
    int errors = 0;

    display_mode_ctrl #(.BLINK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_next  (btn_next),
        .btn_inc   (btn_inc),
        .time_in   (time_in),
        .sw_in     (sw_in),
        .display   (display),
        .blank     (blank),
        .mode      (mode),
        .set_valid (set_valid),
        .set_value (set_value)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_next = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
        time_in = 32'h0; sw_in = 32'h0;
        tick(); tick();
        check("rst_mode", {29'd0, mode}, 32'd0);
        check("rst_display", display, 32'h0);
        check("rst_blank", {24'd0, blank}, 32'h0);
        check("rst_set_valid", {31'd0, set_valid}, 32'd0);
        check("rst_set_value", set_value, 32'h0);
        rst = 1'b0;

        time_in = 32'h12345678; tick();
        check("time_display", display, 32'h12345678);
        check("time_mode", {29'd0, mode}, 32'd0);
        check("time_blank", {24'd0, blank}, 32'h0);
        check("time_set_valid", {31'd0, set_valid}, 32'd0);

        // Stopwatch view ignores next/inc
        sw_in = 32'h00012345; btn_mode = 1'b1; tick();
        check("sw_mode", {29'd0, mode}, 32'd1);
        check("sw_display", display, 32'h00012345);
        btn_inc = 1'b1; tick();
        check("sw_inc_mode", {29'd0, mode}, 32'd1);
        check("sw_inc_display", display, 32'h00012345);
        btn_next = 1'b1; tick();
        check("sw_next_mode", {29'd0, mode}, 32'd1);
        btn_mode = 1'b1; tick();
        check("sw_back_mode", {29'd0, mode}, 32'd0);
        check("sw_back_display", display, 32'h12345678);

        // Full wrap of every field then commit zero
        time_in = 32'h23595999;
        btn_next = 1'b1; tick();
        check("hour_mode", {29'd0, mode}, 32'd2);
        check("hour_capture", display, 32'h23595900);
        btn_inc = 1'b1; tick();
        check("hour_wrap", display, 32'h00595900);
        btn_next = 1'b1; tick();
        check("min_mode", {29'd0, mode}, 32'd3);
        btn_inc = 1'b1; tick();
        check("min_wrap", display, 32'h00005900);
        btn_next = 1'b1; tick();
        check("sec_mode", {29'd0, mode}, 32'd4);
        btn_inc = 1'b1; tick();
        check("sec_wrap", display, 32'h00000000);
        btn_next = 1'b1; tick();
        check("commit0_valid", {31'd0, set_valid}, 32'd1);
        check("commit0_value", set_value, 32'h00000000);
        check("commit0_mode", {29'd0, mode}, 32'd0);
        check("commit0_display", display, 32'h23595999);
        tick();
        check("commit0_pulse_end", {31'd0, set_valid}, 32'd0);

        // Non-zero commit
        time_in = 32'h12345678;
        btn_next = 1'b1; tick();
        btn_inc = 1'b1; tick();
        check("hour_inc", display, 32'h13345600);
        btn_next = 1'b1; tick();
        btn_next = 1'b1; tick();
        btn_inc = 1'b1; tick();
        check("sec_inc", display, 32'h13345700);
        btn_next = 1'b1; tick();
        check("commit1_valid", {31'd0, set_valid}, 32'd1);
        check("commit1_value", set_value, 32'h13345700);
        tick();
        check("commit1_pulse_end", {31'd0, set_valid}, 32'd0);
        check("commit1_hold", set_value, 32'h13345700);

        // mode beats next in SET_SEC: abort, no commit
        btn_next = 1'b1; tick();
        btn_next = 1'b1; tick();
        btn_next = 1'b1; tick();
        check("abort_pre_mode", {29'd0, mode}, 32'd4);
        btn_mode = 1'b1; btn_next = 1'b1; tick();
        check("abort_mode", {29'd0, mode}, 32'd0);
        check("abort_valid", {31'd0, set_valid}, 32'd0);
        check("abort_value", set_value, 32'h13345700);
        tick();
        check("abort_valid2", {31'd0, set_valid}, 32'd0);

        // Blink in SET_MIN
        btn_next = 1'b1; tick();
        btn_next = 1'b1; tick();
        check("blink_mode", {29'd0, mode}, 32'd3);
        check("blink_e0", {24'd0, blank}, 32'h00);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("blink_e%0d", i), {24'd0, blank},
                  (i >= 4 && i < 8) ? 32'h30 : 32'h00);
        end
        tick(); tick(); tick(); tick();
        check("blink_e12", {24'd0, blank}, 32'h30);
        btn_inc = 1'b1; tick();
        check("blink_inc_clr", {24'd0, blank}, 32'h00);
        check("blink_inc_display", display, 32'h12355600);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("blink_after_inc%0d", i), {24'd0, blank}, 32'h00);
        end
        tick();
        check("blink_after_inc4", {24'd0, blank}, 32'h30);
        btn_mode = 1'b1; tick();
        check("blink_abort_mode", {29'd0, mode}, 32'd0);
        check("blink_abort_blank", {24'd0, blank}, 32'h00);

        // Hour boundary values and next-over-inc priority
        time_in = 32'h09000000;
        btn_next = 1'b1; tick();
        btn_next = 1'b1; btn_inc = 1'b1; tick();
        check("prio_mode", {29'd0, mode}, 32'd3);
        check("prio_display", display, 32'h09000000);
        btn_mode = 1'b1; tick();
        btn_next = 1'b1; tick();
        btn_inc = 1'b1; tick();
        check("hour_09_inc", display, 32'h10000000);
        btn_mode = 1'b1; tick();
        time_in = 32'h2A000000;
        btn_next = 1'b1; tick();
        check("hour_2a_capture", display, 32'h2A000000);
        btn_inc = 1'b1; tick();
        check("hour_2a_inc", display, 32'h00000000);
        btn_mode = 1'b1; tick();

        // Reset mid-edit
        time_in = 32'h12345678;
        btn_next = 1'b1; tick();
        btn_next = 1'b1; tick();
        check("rst_edit_pre_mode", {29'd0, mode}, 32'd3);
        rst = 1'b1; tick();
        check("rst_edit_mode", {29'd0, mode}, 32'd0);
        check("rst_edit_display", display, 32'h0);
        check("rst_edit_valid", {31'd0, set_valid}, 32'd0);
        check("rst_edit_value", set_value, 32'h0);
        rst = 1'b0; tick();
        check("post_rst_display", display, 32'h12345678);
        check("post_rst_valid", {31'd0, set_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_mode_ctrl.md
# display_mode_ctrl

Mode and time-set controller sitting in front of the 8-digit seven-segment display path of the FPGA clock. It selects which 32-bit BCD word (live time, stopwatch, or time under edit) drives the display, and runs the button-driven set-time state machine. It also produces a per-digit blank mask that blinks the field being edited, and issues a one-cycle load request carrying the new time to the timekeeper.

## Interface

- BLINK_DIV, 25_000_000: clk cycles per blink half-period (0.5 s at 50 MHz); minimum 2
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- btn_mode  in  1  single-cycle pulse, debounced upstream
- btn_next  in  1  single-cycle pulse, debounced upstream
- btn_inc  in  1  single-cycle pulse, debounced upstream
- time_in  in  32  live BCD time: [31:24] hours, [23:16] minutes, [15:8] seconds, [7:0] hundredths
- sw_in  in  32  stopwatch BCD value, same field layout
- display  out  32  registered BCD word to the seven-segment decoder bank
- blank  out  8  bit i = 1 blanks digit i (hex i)
- mode  out  3  current state encoding
- set_valid  out  1  one-cycle pulse: load set_value into timekeeper
- set_value  out  32  edited time; hundredths always 00

## Operation

- States and mode encoding: SHOW_TIME=0, SHOW_SW=1, SET_HOUR=2, SET_MIN=3, SET_SEC=4; values 5-7 are unused and recover to SHOW_TIME on the next clock.
- Button priority within one cycle: btn_mode > btn_next > btn_inc. Only the highest-priority asserted button acts.
- SHOW_TIME:
  - btn_mode -> SHOW_SW.
  - btn_next -> SET_HOUR; edit register <= {time_in[31:8], 8'h00}.
  - btn_inc is ignored.
- SHOW_SW:
  - btn_mode -> SHOW_TIME.
  - btn_next and btn_inc are ignored.
- SET_HOUR:
  - btn_next -> SET_MIN.
  - btn_inc increments the hours field.
  - btn_mode aborts to SHOW_TIME with no commit.
- SET_MIN: same as SET_HOUR, with btn_next -> SET_SEC and btn_inc acting on the minutes field.
- SET_SEC:
  - btn_next commits: set_valid=1 for one cycle, set_value <= edit register, then -> SHOW_TIME.
  - btn_inc acts on the seconds field.
  - btn_mode aborts with no commit.
- BCD increment of an 8-bit field with max M (hours 8'h23, minutes and seconds 8'h59):
  - field >= M -> 8'h00.
  - else low nibble >= 9 -> low 0, high +1.
  - else low +1.
  - Out-of-range captured values (e.g. 8'h2A) therefore wrap to 00 on the first inc.
- display source:
  - SHOW_TIME: time_in.
  - SHOW_SW: sw_in.
  - SET_*: edit register.
- Blink:
  - Free-running counter 0..BLINK_DIV-1; phase toggles on wrap.
  - Counter and phase clear to 0 on any btn_inc or state change, so the edited field shows immediately.
  - In SET_HOUR with phase=1, blank=8'hC0. In SET_MIN, 8'h30. In SET_SEC, 8'h0C.
  - In all other cases blank=8'h00.
- set_value holds its last committed value until the next commit.

## Timing

- Reset values: state SHOW_TIME, mode=0, display=0, blank=0, set_valid=0, set_value=0, edit=0, blink counter=0, phase=0.
- All outputs are registered. A button pulse in cycle n is reflected in mode, display, blank and set_valid in cycle n+1.
- display lags time_in and sw_in by exactly 1 cycle.
- set_valid is high for exactly one cycle, and set_value is valid in that same cycle.
- Blink period: the first phase=1 occurs BLINK_DIV cycles after the last clear; phase then toggles every BLINK_DIV cycles.
- rst asserted mid-edit discards the edit register, and no set_valid is produced.
- Buttons held high for more than one cycle act once per asserted cycle. No edge detection is performed here.

## Test plan

- Reset, then time_in=32'h12345678 -> one cycle later display=32'h12345678, mode=0, blank=0, set_valid=0.
- btn_mode, then sw_in=32'h00012345 -> mode=1, display=32'h00012345. A btn_inc has no effect. A second btn_mode -> mode=0.
- time_in=32'h23595999. Sequence: btn_next, btn_inc -> display=32'h00595900. btn_next, btn_inc -> display=32'h00005900. btn_next, btn_inc -> display=32'h00000000. btn_next -> one-cycle set_valid with set_value=32'h00000000, mode=0.
- BLINK_DIV=4, in SET_MIN with no buttons -> blank alternates 8'h00 and 8'h30 every 4 cycles. A btn_inc forces blank=8'h00 for the next 4 cycles.
- In SET_SEC, btn_mode and btn_next in the same cycle -> mode=0, set_valid stays 0, and set_value keeps its previous value.
- Captured hours 8'h09 then btn_inc -> 8'h10. Captured 8'h2A then btn_inc -> 8'h00. rst during SET_MIN -> mode=0 and display=0 next cycle.
